// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Arbitrates NUM_REQ byte producers onto a single FIFO write
//               port. A winner owns the port for a locked burst of
//               BEAT_COUNT bytes, so every FIFO read word comes from one
//               producer. The owner cannot be preempted. Valid gaps and
//               fifo_full only stall the burst.
//               Build option FIFO_ARB_FIXED_PRIO_EN selects fixed priority,
//               where the lowest index wins. When it is undefined,
//               arbitration is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BEAT_COUNT = 4,
  parameter int FREE_W     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic [FREE_W-1:0]             fifo_free,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          burst_done
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int IDW1 = IDW + 1;
  localparam int CW   = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;

  localparam logic [FREE_W-1:0] C_BURST_FREE = FREE_W'(BEAT_COUNT);
  localparam logic [CW-1:0]     C_LAST_BEAT  = CW'(BEAT_COUNT - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  grant_id_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            burst_done_q;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic            beat_xfer;
  logic            last_beat;

  // A beat moves only while the owner is valid, the FIFO has room and
  // reset is released. Reset gates the outputs so that nothing leaks out
  // during the cycle in which rst is sampled low.
  assign beat_xfer = (state_q == S_BURST) && rst && !fifo_full && req_valid[grant_id_q];
  assign last_beat = beat_xfer && (beat_cnt_q == C_LAST_BEAT);

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top down so that the lowest valid index
  // is written last and wins.
  always_comb begin
    win_found = |req_valid;
    win_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) win_id = IDW'(i);
    end
  end
`else
  localparam logic [IDW:0] C_NUM = IDW1'(NUM_REQ);

  logic [IDW-1:0] last_owner_q;

  // Round-robin: search upward from last_owner+1 and wrap modulo NUM_REQ.
  always_comb begin
    logic [IDW:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_owner_q} + IDW1'(k);
      if (cand >= C_NUM) cand = cand - C_NUM;
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  // Remember the owner of the most recently completed burst. Reset points
  // the search at index 0 first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner_q <= IDW'(NUM_REQ - 1);
    end else if (last_beat) begin
      last_owner_q <= grant_id_q;
    end
  end
`endif

  // Burst control FSM. It owns the state, the beat counter, the latched
  // grant and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found && (fifo_free >= C_BURST_FREE)) begin
            state_q    <= S_BURST;
            grant_id_q <= win_id;
            beat_cnt_q <= '0;
          end
        end
        S_BURST: begin
          if (last_beat) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b1;
          end else if (beat_xfer) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Only the owner sees ready, and only while the FIFO can take a byte.
  // Data is forced to zero outside of transfers.
  always_comb begin
    req_ready   = '0;
    fifo_w_data = '0;
    if ((state_q == S_BURST) && rst && !fifo_full) begin
      req_ready[grant_id_q] = 1'b1;
    end
    if (beat_xfer) begin
      fifo_w_data = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_en = beat_xfer;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == S_BURST);
  assign burst_done = burst_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter. Define
//               FIFO_ARB_FIXED_PRIO_EN to match the DUT build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  fifo_w_data;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [4:0]  fifo_free;
  logic [1:0]  grant_id;
  logic        busy;
  logic        burst_done;

  int checks;
  int errors;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .BEAT_COUNT(4), .FREE_W(5)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_w_data(fifo_w_data), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_free(fifo_free), .grant_id(grant_id),
    .busy(busy), .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and land just past the edge, where inputs are driven.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling them.
  task automatic settle;
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    fifo_free = 5'd16;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 4'b1111; req_data = 32'h44332211;
    fifo_full = 1'b0; fifo_free = 5'd16;
    tick(); tick(); settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", burst_done); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d want 0", grant_id); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", fifo_wr_en); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    checks++; if (fifo_w_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", fifo_w_data); end
  endtask

  task automatic test_single;
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    do_reset();
    req_valid = 4'b0001; req_data = {24'h0, bytes[0]};
    settle();
    checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL single_idle got wr_en=%b ready=%b want 0/0000", fifo_wr_en, req_ready); end
    tick();
    for (int b = 0; b < 4; b++) begin
      req_data[7:0] = bytes[b];
      settle();
      checks++; if (fifo_wr_en !== 1'b1 || fifo_w_data !== bytes[b]) begin errors++; $display("FAIL single_beat%0d got wr_en=%b data=%h want 1/%h", b, fifo_wr_en, fifo_w_data, bytes[b]); end
      checks++; if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant%0d got id=%0d ready=%b want 0/0001", b, grant_id, req_ready); end
      checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL single_done_early%0d got %b want 0", b, burst_done); end
      tick();
    end
    req_valid = 4'b0000;
    settle();
    checks++; if (burst_done !== 1'b1 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_end got done=%b busy=%b wr_en=%b want 1/0/0", burst_done, busy, fifo_wr_en); end
    tick(); settle();
    checks++; if (burst_done !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL single_after got done=%b id=%0d want 0/0", burst_done, grant_id); end
  endtask

  task automatic test_round_robin;
    int own [5];
    own[0] = 0; own[1] = 1; own[2] = 2; own[3] = 3; own[4] = 0;
    do_reset();
    req_valid = 4'b1111; req_data = 32'hA3A2A1A0;
    for (int n = 0; n < 5; n++) begin
      settle();
      checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got busy=%b wr_en=%b want 0/0", n, busy, fifo_wr_en); end
      tick();
      settle();
      checks++; if (grant_id !== own[n][1:0]) begin errors++; $display("FAIL rr_grant%0d got %0d want %0d", n, grant_id, own[n]); end
      for (int b = 0; b < 4; b++) begin
        settle();
        checks++; if (fifo_wr_en !== 1'b1 || fifo_w_data !== (8'hA0 + 8'(own[n])) || req_ready !== (4'b0001 << own[n])) begin
          errors++; $display("FAIL rr_beat%0d_%0d got wr_en=%b data=%h ready=%b want 1/%h/%b", n, b, fifo_wr_en, fifo_w_data, req_ready, 8'hA0 + 8'(own[n]), 4'b0001 << own[n]);
        end
        tick();
      end
      checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL rr_done%0d got %b want 1", n, burst_done); end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_fifo_full;
    do_reset();
    req_valid = 4'b0001; req_data = {24'h0, 8'h51};
    tick();
    for (int b = 0; b < 2; b++) begin
      req_data[7:0] = 8'h51 + 8'(b);
      settle();
      checks++; if (fifo_wr_en !== 1'b1 || fifo_w_data !== 8'h51 + 8'(b)) begin errors++; $display("FAIL full_pre%0d got wr_en=%b data=%h want 1/%h", b, fifo_wr_en, fifo_w_data, 8'h51 + 8'(b)); end
      tick();
    end
    req_data[7:0] = 8'h53; fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      settle();
      checks++; if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_w_data !== 8'h00 || busy !== 1'b1) begin
        errors++; $display("FAIL full_stall%0d got ready=%b wr_en=%b data=%h busy=%b want 0000/0/00/1", s, req_ready, fifo_wr_en, fifo_w_data, busy);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int b = 2; b < 4; b++) begin
      req_data[7:0] = 8'h51 + 8'(b);
      settle();
      checks++; if (fifo_wr_en !== 1'b1 || fifo_w_data !== 8'h51 + 8'(b) || req_ready !== 4'b0001) begin errors++; $display("FAIL full_post%0d got wr_en=%b data=%h ready=%b want 1/%h/0001", b, fifo_wr_en, fifo_w_data, req_ready, 8'h51 + 8'(b)); end
      tick();
    end
    req_valid = 4'b0000;
    settle();
    checks++; if (burst_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_end got done=%b busy=%b want 1/0", burst_done, busy); end
    tick();
  endtask

  task automatic test_free_threshold;
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000_6600; fifo_free = 5'd3;
    for (int c = 0; c < 3; c++) begin
      tick(); settle();
      checks++; if (busy !== 1'b0 || req_ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL free3_%0d got busy=%b ready=%b wr_en=%b want 0/0000/0", c, busy, req_ready, fifo_wr_en); end
    end
    fifo_free = 5'd4;
    tick(); settle();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL free4_grant got busy=%b id=%0d want 1/1", busy, grant_id); end
    checks++; if (fifo_wr_en !== 1'b1 || fifo_w_data !== 8'h66) begin errors++; $display("FAIL free4_beat got wr_en=%b data=%h want 1/66", fifo_wr_en, fifo_w_data); end
    req_valid = 4'b0000;
    settle();
    checks++; if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0010) begin errors++; $display("FAIL gap_stall got wr_en=%b busy=%b ready=%b want 0/1/0010", fifo_wr_en, busy, req_ready); end
    req_valid = 4'b0010;
    for (int b = 0; b < 4; b++) tick();
    req_valid = 4'b0000;
    settle();
    checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL free4_done got %b want 1", burst_done); end
    tick();
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    req_valid = 4'b0100; req_data = 32'h0077_0000;
    tick(); settle();
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL mid_grant got %0d want 2", grant_id); end
    tick(); tick();
    rst = 1'b0; req_valid = 4'b0101; req_data = 32'h0077_0088;
    settle();
    checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_low got wr_en=%b ready=%b want 0/0000", fifo_wr_en, req_ready); end
    tick(); settle();
    checks++; if (busy !== 1'b0 || burst_done !== 1'b0 || grant_id !== 2'd0 || fifo_wr_en !== 1'b0 || fifo_w_data !== 8'h00 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_outputs got busy=%b done=%b id=%0d wr_en=%b data=%h ready=%b want all 0", busy, burst_done, grant_id, fifo_wr_en, fifo_w_data, req_ready);
    end
    rst = 1'b1;
    tick(); settle();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_w_data !== 8'h88) begin errors++; $display("FAIL mid_regrant got busy=%b id=%0d data=%h want 1/0/88", busy, grant_id, fifo_w_data); end
    for (int b = 0; b < 4; b++) tick();
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_prio;
    int own [3];
`ifdef FIFO_ARB_FIXED_PRIO_EN
    own[0] = 0; own[1] = 0; own[2] = 0;
`else
    own[0] = 0; own[1] = 3; own[2] = 0;
`endif
    do_reset();
    req_valid = 4'b1001; req_data = 32'hD300_00D0;
    for (int n = 0; n < 3; n++) begin
      tick(); settle();
      checks++; if (grant_id !== own[n][1:0] || busy !== 1'b1) begin errors++; $display("FAIL prio_grant%0d got id=%0d busy=%b want %0d/1", n, grant_id, busy, own[n]); end
      for (int b = 0; b < 4; b++) begin
        settle();
        checks++; if (req_ready !== (4'b0001 << own[n])) begin errors++; $display("FAIL prio_ready%0d_%0d got %b want %b", n, b, req_ready, 4'b0001 << own[n]); end
        tick();
      end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0; fifo_free = 5'd16;
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_free_threshold();
    test_reset_mid_burst();
    test_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
